// File: rtl/submodulo_sensor_ir.sv
// submodulo_sensor_ir: infrared presence front-end (synchroniser, debounce, hold stretch, stuck-high fault)
// Ports:
//    clk            in  system clock, posedge
//    rst            in  asynchronous active-low reset
//    ir_raw         in  raw sensor level (async), 1 = detection
//    enable         in  1 = active, 0 = forced idle
//    infravermelho  out conditioned presence
//    deteccao_pulse out one-cycle pulse on AUSENTE->PRESENTE
//    falha          out stuck-high fault flag (only with IR_FAULT_EN defined, else 0)
// Build option: define IR_FAULT_EN to implement the stuck-high counter and FALHA state.
module submodulo_sensor_ir #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE_T  = 1000,
   parameter int HOLD_T      = 500,
   parameter int STUCK_T     = 60000
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_raw,
   input  logic enable,
   output logic infravermelho,
   output logic deteccao_pulse,
   output logic falha
);
   if (SYNC_STAGES < 2 || DEBOUNCE_T < 1 || DEBOUNCE_T > 65535 || HOLD_T < 1 || HOLD_T > 65535 ||
       STUCK_T < 1 || STUCK_T > 65535) begin : g_param_err
      $error("submodulo_sensor_ir: parameter out of range");
   end

   typedef enum logic [1:0] {
      AUSENTE  = 2'd0,
      PRESENTE = 2'd1,
      RETENCAO = 2'd2
`ifdef IR_FAULT_EN
      , FALHA  = 2'd3
`endif
   } state_t;

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_T - 1);
   localparam logic [15:0] HO_LAST = 16'(HOLD_T - 1);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return v + 16'(v != 16'hFFFF);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ir_s;
   logic                   filt_q, filt_d;
   logic [15:0]            db_cnt_q, db_cnt_d;
   logic [15:0]            ho_cnt_q, ho_cnt_d;
   state_t                 state_q, state_d;
   logic                   ir_q, pulse_q;

   assign ir_s = sync_q[SYNC_STAGES-1];

`ifdef IR_FAULT_EN
   localparam logic [15:0] ST_LAST = 16'(STUCK_T - 1);
   logic [15:0] st_cnt_q, st_cnt_d;
   logic        falha_q;
   assign falha = falha_q;
`else
   assign falha = 1'b0;
`endif

   always_comb begin
      // a change of the synchronised level must persist DEBOUNCE_T cycles before filt follows
      filt_d   = (ir_s != filt_q && db_cnt_q == DB_LAST) ? ir_s : filt_q;
      db_cnt_d = (ir_s == filt_q || db_cnt_q == DB_LAST) ? 16'd0 : sat_inc(db_cnt_q);
      state_d  = state_q;
      ho_cnt_d = 16'd0;
      case (state_q)
         AUSENTE:  state_d = filt_q ? PRESENTE : AUSENTE;
`ifdef IR_FAULT_EN
         PRESENTE: state_d = !filt_q ? RETENCAO : (st_cnt_q == ST_LAST) ? FALHA : PRESENTE;
         FALHA:    state_d = filt_q ? FALHA : AUSENTE;
`else
         PRESENTE: state_d = filt_q ? PRESENTE : RETENCAO;
`endif
         RETENCAO: begin
            // a retrigger wins over hold expiry in the same cycle
            state_d  = filt_q ? PRESENTE : (ho_cnt_q == HO_LAST) ? AUSENTE : RETENCAO;
            ho_cnt_d = (state_d == RETENCAO) ? sat_inc(ho_cnt_q) : 16'd0;
         end
         default:  state_d = AUSENTE;
      endcase
`ifdef IR_FAULT_EN
      st_cnt_d = (state_q == PRESENTE && state_d == PRESENTE) ? sat_inc(st_cnt_q) : 16'd0;
`endif
      if (!enable) begin
         filt_d   = 1'b0;
         db_cnt_d = 16'd0;
         ho_cnt_d = 16'd0;
         state_d  = AUSENTE;
`ifdef IR_FAULT_EN
         st_cnt_d = 16'd0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q   <= '0;
         filt_q   <= 1'b0;
         db_cnt_q <= 16'd0;
         ho_cnt_q <= 16'd0;
         state_q  <= AUSENTE;
         ir_q     <= 1'b0;
         pulse_q  <= 1'b0;
`ifdef IR_FAULT_EN
         st_cnt_q <= 16'd0;
         falha_q  <= 1'b0;
`endif
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], ir_raw};
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
         ho_cnt_q <= ho_cnt_d;
         state_q  <= state_d;
         // outputs are registered copies of the next-state decode, so they track state_q exactly
         ir_q     <= (state_d == PRESENTE || state_d == RETENCAO);
         pulse_q  <= (state_q == AUSENTE && state_d == PRESENTE);
`ifdef IR_FAULT_EN
         st_cnt_q <= st_cnt_d;
         falha_q  <= (state_d == FALHA);
`endif
      end
   end

   assign infravermelho  = ir_q;
   assign deteccao_pulse = pulse_q;
endmodule

// File: tb/tb_submodulo_sensor_ir.sv
// tb_submodulo_sensor_ir: directed self-checking bench for submodulo_sensor_ir
module tb_submodulo_sensor_ir;
   logic clk = 1'b0;
   logic rst, ir_raw, enable;
   logic infravermelho, deteccao_pulse, falha;
   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   submodulo_sensor_ir #(.SYNC_STAGES(2), .DEBOUNCE_T(4), .HOLD_T(8), .STUCK_T(32)) dut (
      .clk(clk),
      .rst(rst),
      .ir_raw(ir_raw),
      .enable(enable),
      .infravermelho(infravermelho),
      .deteccao_pulse(deteccao_pulse),
      .falha(falha)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (deteccao_pulse === 1'b1) pulse_cnt++;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      enable = 1'b1;
      ir_raw = 1'b1;
      #1;
      checks++;
      if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
         errors++;
         $display("FAIL reset_t0 got %b exp 000", {infravermelho, deteccao_pulse, falha});
      end
      step(3);
      checks++;
      if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
         errors++;
         $display("FAIL reset_hold got %b exp 000", {infravermelho, deteccao_pulse, falha});
      end
      ir_raw = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         checks++;
         if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset cyc %0d got %b exp 000", i, {infravermelho, deteccao_pulse, falha});
         end
      end
   endtask

   task automatic test_rise();
      int p0 = pulse_cnt;
      ir_raw = 1'b1;
      step(6);
      checks++;
      if ({infravermelho, deteccao_pulse} !== 2'b00) begin
         errors++;
         $display("FAIL rise_edge6 got %b exp 00", {infravermelho, deteccao_pulse});
      end
      step(1);
      checks++;
      if ({infravermelho, deteccao_pulse} !== 2'b11) begin
         errors++;
         $display("FAIL rise_edge7 got %b exp 11", {infravermelho, deteccao_pulse});
      end
      step(1);
      checks++;
      if ({infravermelho, deteccao_pulse} !== 2'b10) begin
         errors++;
         $display("FAIL rise_edge8 got %b exp 10", {infravermelho, deteccao_pulse});
      end
      ir_raw = 1'b0;
      step(20);
      checks++;
      if (infravermelho !== 1'b0 || pulse_cnt !== p0 + 1) begin
         errors++;
         $display("FAIL rise_settle ir %b pulses %0d exp ir 0 pulses %0d", infravermelho, pulse_cnt - p0, 1);
      end
   endtask

   task automatic test_glitch();
      int p0 = pulse_cnt;
      ir_raw = 1'b1;
      step(3);
      ir_raw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         checks++;
         if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
            errors++;
            $display("FAIL glitch cyc %0d got %b exp 000", i, {infravermelho, deteccao_pulse, falha});
         end
      end
      checks++;
      if (pulse_cnt !== p0) begin
         errors++;
         $display("FAIL glitch_pulses got %0d exp 0", pulse_cnt - p0);
      end
   endtask

   task automatic test_hold();
      ir_raw = 1'b1;
      step(10);
      ir_raw = 1'b0;
      step(14);
      checks++;
      if (infravermelho !== 1'b1) begin
         errors++;
         $display("FAIL hold_edge14 got %b exp 1", infravermelho);
      end
      step(1);
      checks++;
      if (infravermelho !== 1'b0) begin
         errors++;
         $display("FAIL hold_edge15 got %b exp 0", infravermelho);
      end
   endtask

   task automatic test_retrigger();
      int p0 = pulse_cnt;
      ir_raw = 1'b1;
      step(10);
      ir_raw = 1'b0;
      step(4);
      ir_raw = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step(1);
         checks++;
         if (infravermelho !== 1'b1) begin
            errors++;
            $display("FAIL retrig_hold cyc %0d got %b exp 1", i, infravermelho);
         end
      end
      checks++;
      if (pulse_cnt !== p0 + 1) begin
         errors++;
         $display("FAIL retrig_pulses got %0d exp 1", pulse_cnt - p0);
      end
      ir_raw = 1'b0;
      step(14);
      checks++;
      if (infravermelho !== 1'b1) begin
         errors++;
         $display("FAIL retrig_fall14 got %b exp 1", infravermelho);
      end
      step(1);
      checks++;
      if (infravermelho !== 1'b0) begin
         errors++;
         $display("FAIL retrig_fall15 got %b exp 0", infravermelho);
      end
   endtask

   task automatic test_fault();
      ir_raw = 1'b1;
      step(7);
      checks++;
      if (infravermelho !== 1'b1) begin
         errors++;
         $display("FAIL fault_enter got %b exp 1", infravermelho);
      end
      step(31);
      checks++;
      if ({infravermelho, falha} !== 2'b10) begin
         errors++;
         $display("FAIL fault_pre32 got %b exp 10", {infravermelho, falha});
      end
      step(1);
`ifdef IR_FAULT_EN
      checks++;
      if ({infravermelho, falha} !== 2'b01) begin
         errors++;
         $display("FAIL fault_at32 got %b exp 01", {infravermelho, falha});
      end
      step(21);
      checks++;
      if ({infravermelho, falha} !== 2'b01) begin
         errors++;
         $display("FAIL fault_stays got %b exp 01", {infravermelho, falha});
      end
      ir_raw = 1'b0;
      step(6);
      checks++;
      if (falha !== 1'b1) begin
         errors++;
         $display("FAIL fault_clear6 got %b exp 1", falha);
      end
      step(1);
      checks++;
      if ({infravermelho, falha} !== 2'b00) begin
         errors++;
         $display("FAIL fault_clear7 got %b exp 00", {infravermelho, falha});
      end
`else
      checks++;
      if ({infravermelho, falha} !== 2'b10) begin
         errors++;
         $display("FAIL nofault_at32 got %b exp 10", {infravermelho, falha});
      end
      step(21);
      checks++;
      if ({infravermelho, falha} !== 2'b10) begin
         errors++;
         $display("FAIL nofault_stays got %b exp 10", {infravermelho, falha});
      end
      ir_raw = 1'b0;
      step(15);
      checks++;
      if ({infravermelho, falha} !== 2'b00) begin
         errors++;
         $display("FAIL nofault_release got %b exp 00", {infravermelho, falha});
      end
`endif
      step(5);
   endtask

   task automatic test_enable_reset();
      ir_raw = 1'b1;
      step(7);
      checks++;
      if (infravermelho !== 1'b1) begin
         errors++;
         $display("FAIL en_present got %b exp 1", infravermelho);
      end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++;
         if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
            errors++;
            $display("FAIL en_off cyc %0d got %b exp 000", i, {infravermelho, deteccao_pulse, falha});
         end
      end
      enable = 1'b1;
      step(4);
      checks++;
      if (infravermelho !== 1'b0) begin
         errors++;
         $display("FAIL reen_edge4 got %b exp 0", infravermelho);
      end
      step(1);
      checks++;
      if ({infravermelho, deteccao_pulse} !== 2'b11) begin
         errors++;
         $display("FAIL reen_edge5 got %b exp 11", {infravermelho, deteccao_pulse});
      end
      ir_raw = 1'b0;
      step(10);
      checks++;
      if (infravermelho !== 1'b1) begin
         errors++;
         $display("FAIL retencao_mid got %b exp 1", infravermelho);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({infravermelho, deteccao_pulse, falha} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got %b exp 000", {infravermelho, deteccao_pulse, falha});
      end
      ir_raw = 1'b1;
      step(2);
      rst = 1'b1;
      step(6);
      checks++;
      if (infravermelho !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_edge6 got %b exp 0", infravermelho);
      end
      step(1);
      checks++;
      if ({infravermelho, deteccao_pulse} !== 2'b11) begin
         errors++;
         $display("FAIL post_rst_edge7 got %b exp 11", {infravermelho, deteccao_pulse});
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_hold();
      test_retrigger();
      test_fault();
      test_enable_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
